// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: state encoding and serial line levels shared by the FIFO serial transmitter.
package fifo_tx_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: clk_div down-counter; tick marks the last clock of each bit period.
module bit_timer #(
   parameter int clk_div = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int CW = $clog2(clk_div);
   localparam logic [CW-1:0] TOP = CW'(clk_div - 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= (restart || cnt == '0) ? TOP : cnt - 1'b1;
   assign tick = cnt == '0;
endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops FIFO words and sends them LSB-first with start/stop framing.
module fifo_serial_tx
   import fifo_tx_pkg::*;
#(
   parameter int bits    = 8,
   parameter int clk_div = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            pndng,
   input  logic [bits-1:0] Din,
   output logic            pop,
   output logic            tx,
   output logic            busy,
   output logic            done
);
   localparam int BW = $clog2(bits) + 1;
   localparam logic [BW-1:0] LAST = BW'(bits - 1);
   state_t          state;
   logic [bits-1:0] sh;
   logic [BW-1:0]   bcnt;
   logic            tick;
   logic            accept;
   assign accept = state == IDLE && pndng && en;
   // restarting on acceptance aligns every bit period to the frame start
   bit_timer #(.clk_div(clk_div)) u_timer (
      .clk(clk),
      .rst(rst),
      .restart(accept),
      .tick(tick)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         sh    <= '0;
         bcnt  <= '0;
         tx    <= LINE_IDLE;
         pop   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         pop  <= accept;
         done <= 1'b0;
         case (state)
            IDLE:
               if (accept) begin
                  sh    <= Din;
                  bcnt  <= '0;
                  tx    <= START_BIT;
                  busy  <= 1'b1;
                  state <= START;
               end
            START:
               if (tick) begin
                  tx    <= sh[0];
                  state <= DATA;
               end
            DATA:
               if (tick) begin
                  sh   <= sh >> 1;
                  bcnt <= bcnt + 1'b1;
                  // next line level is the bit about to land in sh[0]
                  if (bcnt == LAST) begin
                     tx    <= STOP_BIT;
                     state <= STOP;
                  end else tx <= sh[1];
               end
            STOP:
               if (tick) begin
                  tx    <= LINE_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
         endcase
      end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: randomized and directed checks against a frame-position reference model.
module tb_fifo_serial_tx;
   localparam int BITS  = 8;
   localparam int DIV   = 4;
   localparam int FRAME = (BITS + 2) * DIV;
   logic clk = 1'b0, rst = 1'b0, en = 1'b0, pndng = 1'b0;
   logic [BITS-1:0] Din = '0;
   logic pop, tx, busy, done;
   int checks = 0, errors = 0, cyc = 0;
   logic [BITS-1:0] q[$];
   bit use_fifo = 1'b1;
   logic last_pop = 1'b0;
   int mpos = -1;
   logic [BITS-1:0] mword = '0;
   logic mdone = 1'b0;

   always #5 clk = ~clk;

   fifo_serial_tx #(.bits(BITS), .clk_div(DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .pndng(pndng), .Din(Din),
      .pop(pop), .tx(tx), .busy(busy), .done(done)
   );

   // model: frame position p (0..FRAME-1) maps to line slot p/DIV of {start, data LSB-first, stop}
   function automatic logic [3:0] exp_out();
      logic t;
      int s;
      s = mpos / DIV;
      t = (mpos < 0) ? 1'b1 : (s == 0) ? 1'b0 : (s <= BITS) ? mword[s-1] : 1'b1;
      return {t, mpos == 0, mpos >= 0, mdone};
   endfunction

   task automatic drive();
      if (use_fifo) begin
         pndng = q.size() > 0;
         Din = (q.size() > 0) ? q[0] : BITS'($urandom);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) begin
         mpos = -1;
         mdone = 1'b0;
      end else begin
         if (last_pop && q.size() > 0) q.delete(0);
         mdone = 1'b0;
         if (mpos < 0) begin
            if (pndng && en) begin
               mpos = 0;
               mword = Din;
            end
         end else if (++mpos == FRAME) begin
            mpos = -1;
            mdone = 1'b1;
         end
      end
      @(negedge clk);
      last_pop = pop;
      cyc++;
      drive();
   endtask

   task automatic test_reset();
      use_fifo = 1'b0;
      rst = 1'b0;
      repeat (20) begin
         en = 1'($urandom);
         pndng = 1'($urandom);
         Din = BITS'($urandom);
         step();
         checks++;
         if ({tx, pop, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=1000", cyc, {tx, pop, busy, done});
         end
      end
      use_fifo = 1'b1;
      en = 1'b0;
      rst = 1'b1;
      drive();
      repeat (50) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got=%b exp=1000", cyc, {tx, pop, busy, done});
         end
      end
   endtask

   task automatic test_single();
      int c = 0, pops = 0, popc = -1, busy_n = 0, done_at = -1;
      logic [9:0] slots = 'x;
      logic [9:0] exp_slots = 10'b1101001010;
      en = 1'b1;
      q.push_back(8'hA5);
      drive();
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
         if (c == 0 && pop) c = 1;
         else if (c > 0) c++;
         if (c > 0 && c <= 45) begin
            if (pop) begin pops++; popc = c; end
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = c;
            if (c % 4 == 2 && c <= 40) slots[(c-1)/4] = tx;
         end
      end
      checks++;
      if (c == 0) begin errors++; $display("FAIL single_timeout got=no_pop exp=pop"); end
      checks++;
      if (pops != 1 || popc != 1) begin
         errors++;
         $display("FAIL single_pop got=%0d pops at %0d exp=1 pop at 1", pops, popc);
      end
      checks++;
      if (busy_n != 40) begin errors++; $display("FAIL single_busy got=%0d exp=40", busy_n); end
      checks++;
      if (done_at != 41) begin errors++; $display("FAIL single_done got=%0d exp=41", done_at); end
      checks++;
      if (slots !== exp_slots) begin
         errors++;
         $display("FAIL single_slots got=%b exp=%b", slots, exp_slots);
      end
   endtask

   task automatic test_back_to_back();
      int npops = 0, p1 = 0, p2 = 0, idle_between = 0, c2 = 0, zeros = 0;
      en = 1'b1;
      q.push_back(8'h01);
      q.push_back(8'hFF);
      drive();
      for (int i = 0; i < 120; i++) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
         if (pop) begin
            npops++;
            if (npops == 1) p1 = cyc;
            else if (npops == 2) p2 = cyc;
         end
         if (npops == 1 && !busy) idle_between++;
         if (npops >= 2) c2++;
         if (c2 >= 5 && c2 <= 36 && tx !== 1'b1) zeros++;
      end
      checks++;
      if (npops != 2 || p2 - p1 != 41) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d pops gap %0d exp=2 pops gap 41", npops, p2 - p1);
      end
      checks++;
      if (idle_between != 1) begin errors++; $display("FAIL b2b_idle got=%0d exp=1", idle_between); end
      checks++;
      if (zeros != 0 || c2 < 36) begin
         errors++;
         $display("FAIL b2b_ff_bits got=%0d zeros over %0d cycles exp=0 zeros over 36", zeros, c2);
      end
   endtask

   task automatic test_en_gate();
      int pops = 0, lows = 0;
      en = 1'b0;
      q.push_back(BITS'($urandom));
      drive();
      repeat (100) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL en_gate cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
         if (pop) pops++;
         if (!tx) lows++;
      end
      checks++;
      if (pops != 0 || lows != 0) begin
         errors++;
         $display("FAIL en_gate_idle got=%0d pops %0d low exp=0 pops 0 low", pops, lows);
      end
      en = 1'b1;
      step();
      checks++;
      if (pop !== 1'b1) begin errors++; $display("FAIL en_gate_accept got=%b exp=1", pop); end
      repeat (50) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL en_gate_frame cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
      end
   endtask

   task automatic test_reset_mid();
      int pops = 0, dones = 0;
      bit hit = 1'b0;
      en = 1'b1;
      q.push_back(BITS'($urandom));
      drive();
      for (int i = 0; i < 60 && !hit; i++) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL rst_mid cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
         hit = mpos == 4 + 3 * DIV + 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rst_mid_timeout got=no_bit3 exp=bit3"); end
      rst = 1'b0;
      mpos = -1;
      mdone = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async got=tx%b busy%b exp=tx1 busy0", tx, busy);
      end
      repeat (3) step();
      rst = 1'b1;
      drive();
      repeat (60) begin
         step();
         if (pop) pops++;
         if (done) dones++;
      end
      checks++;
      if (pops != 0 || dones != 0) begin
         errors++;
         $display("FAIL rst_mid_after got=%0d pops %0d dones exp=0 pops 0 dones", pops, dones);
      end
   endtask

   task automatic test_en_drop();
      int pops = 0, dones = 0;
      logic [BITS-1:0] seen = 'x;
      en = 1'b1;
      q.push_back(8'h3C);
      q.push_back(BITS'($urandom));
      drive();
      repeat (150) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL en_drop cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
         if (pop) pops++;
         if (done) dones++;
         if (mpos >= 4 && mpos < 4 + BITS * DIV && (mpos - 4) % DIV == 1) seen[(mpos-4)/DIV] = tx;
         if (mpos == 10) en = 1'b0;
      end
      checks++;
      if (seen !== 8'h3C) begin errors++; $display("FAIL en_drop_bits got=%h exp=3c", seen); end
      checks++;
      if (pops != 1 || dones != 1) begin
         errors++;
         $display("FAIL en_drop_count got=%0d pops %0d dones exp=1 pop 1 done", pops, dones);
      end
   endtask

   task automatic test_random();
      bit drained = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) q.push_back(BITS'($urandom));
         if ($urandom_range(0, 15) == 0) en = ~en;
         drive();
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
      end
      en = 1'b1;
      drive();
      for (int i = 0; i < 3000 && !drained; i++) begin
         step();
         checks++;
         if ({tx, pop, busy, done} !== exp_out()) begin
            errors++;
            $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc, {tx, pop, busy, done}, exp_out());
         end
         drained = q.size() == 0 && mpos < 0;
      end
      checks++;
      if (!drained) begin errors++; $display("FAIL random_timeout got=%0d left exp=0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_en_gate();
      test_reset_mid();
      test_en_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
